mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum number of consecutive data grants while a fetch request waits.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles from mem_en to mem_done before the access is abandoned.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 if_req  in  1  fetch request, held high until if_done.
REQ-006 if_addr  in  16  fetch address.
REQ-007 dm_req  in  1  data request (DMemEn), held high until dm_done.
REQ-008 dm_wr  in  1  data access is a write.
REQ-009 dm_addr  in  16  data address.
REQ-010 dm_wdata  in  16  data write value.
REQ-011 mem_done  in  1  memory completion pulse.
REQ-012 mem_rdata  in  16  memory read data, valid with mem_done.
REQ-013 mem_en  out  1  one-cycle memory start strobe.
REQ-014 mem_wr  out  1  memory write, valid with mem_en.
REQ-015 mem_addr  out  16  memory address, held stable from mem_en until mem_done.
REQ-016 mem_wdata  out  16  memory write data, held stable with mem_addr.
REQ-017 if_done / dm_done  out  1 each  one-cycle completion pulse per requester.
REQ-018 if_rdata / dm_rdata  out  16 each  read data, valid with the matching done and held until the next done for that requester.
REQ-019 if_stall / dm_stall  out  1 each  requester is pending without done this cycle.
REQ-020 err  out  1  sticky protocol/timeout error.

Function
REQ-021 FSM states SHALL be IDLE, IF_ACC, DM_ACC.
REQ-022 In IDLE with any request, arbitration SHALL run at the clock edge; the winner's state is entered and mem_en SHALL be high for exactly the first cycle in that state.
REQ-023 On a simultaneous request, data SHALL win unless starve_cnt equals STARVE_LIMIT, in which case fetch wins.
REQ-024 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each data grant made while if_req is high, and clear on any fetch grant.
REQ-025 mem_wr SHALL equal dm_wr latched at grant for DM_ACC and 0 for IF_ACC.
REQ-026 In an ACC state, mem_done SHALL produce the matching done pulse and registered rdata on the next cycle, with a return to IDLE.
REQ-027 Back-to-back: minimum spacing between successive mem_en pulses SHALL be 3 cycles (grant, done, IDLE).
REQ-028 if_stall SHALL equal if_req and not if_done; dm_stall SHALL equal dm_req and not dm_done (combinational).
REQ-029 A 5-bit wait counter SHALL clear on mem_en and increment each ACC cycle; reaching TIMEOUT without mem_done SHALL set err, return to IDLE, and produce no done pulse.
REQ-030 mem_done in IDLE SHALL set err and be otherwise ignored.
REQ-031 Requests deasserted mid-access SHALL not abort the access; the done pulse SHALL still be issued.

Reset
REQ-032 rst SHALL force IDLE, starve_cnt 0, wait counter 0, err 0, and all outputs 0 (including rdata registers), abandoning any in-flight access.
REQ-033 After rst falls, the first grant SHALL occur no earlier than the first rising edge with rst low.

Structure
REQ-034 FSM state encodings and the default STARVE_LIMIT/TIMEOUT values SHALL live in the shared pipeline package.
REQ-035 A single sub-module, arb_starve_cnt (saturating counter with clear), is natural; everything else is flat.

Verification
REQ-036 Fetch only: if_req=1, addr 0x0010, mem_done 2 cycles after mem_en with rdata 0xBEEF -> if_done pulse with if_rdata=0xBEEF, mem_wr=0.
REQ-037 Simultaneous: if_req and dm_req both high continuously -> grants DM,DM,DM,DM,IF; starve_cnt returns to 0.
REQ-038 Data write: dm_wr=1, addr 0x00F0, wdata 0x1234 -> mem_en with mem_wr=1, mem_addr=0x00F0, mem_wdata=0x1234, stable until mem_done.
REQ-039 Timeout: no mem_done for 16 cycles -> err=1, state IDLE, no done pulse; next request still served.
REQ-040 Reset mid-access: rst asserted in DM_ACC -> all outputs 0 immediately; a later mem_done in IDLE sets err.
REQ-041 Stall check: dm_req held 5 cycles -> dm_stall high every cycle except the dm_done cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types, state encoding and default limits for the fetch/data memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W           = 16;
  localparam int DATA_W           = 16;
  localparam int WAIT_W           = 5;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int TIMEOUT_DEF      = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_ACC = 2'd1,
    ST_DM_ACC = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Data normally wins; fetch wins when alone or once data has starved it long enough.
  function automatic logic fetch_wins(input logic if_req, input logic dm_req, input logic starved);
    return if_req && (!dm_req || starved);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle of the arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              dm_req;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              if_done;
  logic              dm_done;
  logic [DATA_W-1:0] if_rdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              if_stall;
  logic              dm_stall;
  logic              err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_done, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, if_done, dm_done, if_rdata, dm_rdata,
           if_stall, dm_stall, err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_done, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, if_done, dm_done, if_rdata, dm_rdata,
           if_stall, dm_stall, err
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants made while a fetch request was waiting.
module arb_starve_cnt #(
  parameter int  LIMIT = 4,
  localparam int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MAX = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) single-port memory arbiter with starvation guard and access timeout.
// state     | meaning
// ST_IDLE   | no access in flight; arbitrate unless a done pulse is being issued
// ST_IF_ACC | fetch access in flight, waiting for mem_done
// ST_DM_ACC | data access in flight, waiting for mem_done
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int                SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              mem_en_q, mem_en_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;

  logic              grant_if;
  logic              grant_dm;
  logic [SW-1:0]     starve_cnt;
  logic              starved;

  assign starved = (starve_cnt == STARVE_MAX);

  arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .clr_i (grant_if),
    .inc_i (grant_dm && bus.if_req),
    .cnt_o (starve_cnt)
  );

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    cmd_d      = cmd_q;
    mem_en_d   = 1'b0;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    err_d      = err_q;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.mem_done) begin
          err_d = 1'b1;
        end
        // Hold off one cycle after a done so the finished requester can drop its request.
        if (!(if_done_q || dm_done_q) && (bus.if_req || bus.dm_req)) begin
          if (fetch_wins(bus.if_req, bus.dm_req, starved)) begin
            grant_if = 1'b1;
            state_d  = ST_IF_ACC;
            cmd_d    = '{wr: 1'b0, addr: bus.if_addr, wdata: '0};
          end else begin
            grant_dm = 1'b1;
            state_d  = ST_DM_ACC;
            cmd_d    = '{wr: bus.dm_wr, addr: bus.dm_addr, wdata: bus.dm_wdata};
          end
          mem_en_d = 1'b1;
          wait_d   = '0;
        end
      end

      ST_IF_ACC, ST_DM_ACC: begin
        if (bus.mem_done) begin
          state_d = ST_IDLE;
          if (state_q == ST_IF_ACC) begin
            if_done_d  = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end else begin
            dm_done_d  = 1'b1;
            dm_rdata_d = bus.mem_rdata;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      cmd_q      <= '0;
      mem_en_q   <= 1'b0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      cmd_q      <= cmd_d;
      mem_en_q   <= mem_en_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      err_q      <= err_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = cmd_q.wr;
  assign bus.mem_addr  = cmd_q.addr;
  assign bus.mem_wdata = cmd_q.wdata;
  assign bus.if_done   = if_done_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.err       = err_q;

  // Stalls are forced low while in reset so every output reads zero.
  assign bus.if_stall  = !rst && bus.if_req && !if_done_q;
  assign bus.dm_stall  = !rst && bus.dm_req && !dm_done_q;

endmodule
